// File: rtl/alu_result_fifo.sv
// Result buffer behind the 4-bit ALU: tags each result with status flags and
// queues the records in a DEPTH-entry FIFO with valid/ready on both sides.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [4:0]               in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_op,
  output logic [4:0]               out_result,
  output logic                     out_zero,
  output logic                     out_ovf,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 11;  // {op[2:0], result[4:0], zero, ovf, err}

  // Illegal opcodes (5..7) keep the op for diagnosis but carry a zeroed result.
  function automatic logic [RW-1:0] form_record(input logic [2:0] op,
                                                input logic [4:0] res);
    logic [RW-1:0] rec;
    if (op > 3'd4) rec = {op, 5'b0, 1'b1, 1'b0, 1'b1};
    else           rec = {op, res, (res == 5'b0), res[4], 1'b0};
    return rec;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [RW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_ovf_cnt;

  logic             w_push;
  logic             w_pop;
  logic [RW-1:0]    w_rec;
  logic [RW-1:0]    w_head;

  assign in_ready  = (r_level != LW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_rec     = form_record(in_op, in_result);

  // Stage p0: record storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  // Stage p0: pointers, occupancy and overflow counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_push && w_rec[1]) r_ovf_cnt <= sat_inc(r_ovf_cnt);
    end
  end

  // Empty FIFO presents an all-zero head so stale slots never leak out.
  assign w_head     = out_valid ? r_mem[r_rptr] : '0;
  assign out_op     = w_head[10:8];
  assign out_result = w_head[7:3];
  assign out_zero   = w_head[2];
  assign out_ovf    = w_head[1];
  assign out_err    = w_head[0];
  assign level      = r_level;
  assign ovf_count  = r_ovf_cnt;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: vector table plus hand sequences for
// steady-state streaming, counter saturation and mid-stream reset.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] in_op, out_op;
  logic [4:0] in_result, out_result;
  logic       out_zero, out_ovf, out_err;
  logic [2:0] level;
  logic [7:0] ovf_count;

  // Instance B: narrow counter for saturation
  logic       b_reset;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0] b_in_op, b_out_op;
  logic [4:0] b_in_result, b_out_result;
  logic       b_out_zero, b_out_ovf, b_out_err;
  logic [2:0] b_level;
  logic [1:0] b_ovf_count;

  alu_result_fifo #(.DEPTH(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err),
    .level(level), .ovf_count(ovf_count)
  );

  alu_result_fifo #(.DEPTH(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(b_reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_result(b_in_result),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_op(b_out_op), .out_result(b_out_result),
    .out_zero(b_out_zero), .out_ovf(b_out_ovf), .out_err(b_out_err),
    .level(b_level), .ovf_count(b_ovf_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [2:0] op;
    logic [4:0] res;
    logic       ordy;
    logic       ev;
    logic       erdy;
    logic [2:0] eop;
    logic [4:0] eres;
    logic       ez;
    logic       eo;
    logic       ee;
    int         elvl;
    int         ecnt;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [2:0] op, logic [4:0] res, logic ordy,
                              logic ev, logic erdy, logic [2:0] eop, logic [4:0] eres,
                              logic ez, logic eo, logic ee, int elvl, int ecnt);
    vec_t v;
    v.iv = iv; v.op = op; v.res = res; v.ordy = ordy;
    v.ev = ev; v.erdy = erdy; v.eop = eop; v.eres = eres;
    v.ez = ez; v.eo = eo; v.ee = ee; v.elvl = elvl; v.ecnt = ecnt;
    return v;
  endfunction

  // Expected {op, result, zero, ovf, err} for a pushed record.
  function automatic logic [10:0] exp_rec(input logic [2:0] op, input logic [4:0] res);
    if (op >= 3'd5) return {op, 5'd0, 1'b1, 1'b0, 1'b1};
    return {op, res, (res == 5'd0), (res >= 5'd16), 1'b0};
  endfunction

  task automatic tick_a;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [18];
  logic [10:0] q[$];
  logic [10:0] r;
  int exp_cnt;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_result = '0; out_ready = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_op = '0; b_in_result = '0; b_out_ready = 1'b0;

    //         iv  op    res     ordy ev rdy eop   eres    z  o  e  lvl cnt
    tbl[0]  = mk(1, 3'd0, 5'd13, 0,   1, 1, 3'd0, 5'd13, 0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 3'd0, 5'd0,  1,   0, 1, 3'd0, 5'd0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 3'd2, 5'd30, 0,   1, 1, 3'd2, 5'd30, 0, 1, 0, 1, 1);
    tbl[3]  = mk(1, 3'd1, 5'd0,  0,   1, 1, 3'd2, 5'd30, 0, 1, 0, 2, 1);
    tbl[4]  = mk(0, 3'd0, 5'd0,  1,   1, 1, 3'd1, 5'd0,  1, 0, 0, 1, 1);
    tbl[5]  = mk(0, 3'd0, 5'd0,  1,   0, 1, 3'd0, 5'd0,  0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 3'd6, 5'd21, 0,   1, 1, 3'd6, 5'd0,  1, 0, 1, 1, 1);
    tbl[7]  = mk(0, 3'd0, 5'd0,  1,   0, 1, 3'd0, 5'd0,  0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 3'd3, 5'd1,  0,   1, 1, 3'd3, 5'd1,  0, 0, 0, 1, 1);
    tbl[9]  = mk(1, 3'd3, 5'd2,  0,   1, 1, 3'd3, 5'd1,  0, 0, 0, 2, 1);
    tbl[10] = mk(1, 3'd3, 5'd3,  0,   1, 1, 3'd3, 5'd1,  0, 0, 0, 3, 1);
    tbl[11] = mk(1, 3'd3, 5'd4,  0,   1, 0, 3'd3, 5'd1,  0, 0, 0, 4, 1);
    tbl[12] = mk(1, 3'd0, 5'd9,  0,   1, 0, 3'd3, 5'd1,  0, 0, 0, 4, 1);
    tbl[13] = mk(1, 3'd0, 5'd9,  1,   1, 1, 3'd3, 5'd2,  0, 0, 0, 3, 1);
    tbl[14] = mk(0, 3'd0, 5'd0,  1,   1, 1, 3'd3, 5'd3,  0, 0, 0, 2, 1);
    tbl[15] = mk(0, 3'd0, 5'd0,  1,   1, 1, 3'd3, 5'd4,  0, 0, 0, 1, 1);
    tbl[16] = mk(0, 3'd0, 5'd0,  1,   0, 1, 3'd0, 5'd0,  0, 0, 0, 0, 1);
    tbl[17] = mk(0, 3'd0, 5'd0,  1,   0, 1, 3'd0, 5'd0,  0, 0, 0, 0, 1);

    tick_a; tick_a;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_out_fields", {out_op, out_result, out_zero, out_ovf, out_err}, 0);
    chk("rst_b_count", b_ovf_count, 0);
    reset = 1'b0;
    b_reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].iv; in_op = tbl[i].op; in_result = tbl[i].res;
      out_ready = tbl[i].ordy;
      tick_a;
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].erdy);
      chk($sformatf("v%0d_out_op", i), out_op, tbl[i].eop);
      chk($sformatf("v%0d_out_result", i), out_result, tbl[i].eres);
      chk($sformatf("v%0d_flags", i), {out_zero, out_ovf, out_err},
          {tbl[i].ez, tbl[i].eo, tbl[i].ee});
      chk($sformatf("v%0d_level", i), level, tbl[i].elvl);
      chk($sformatf("v%0d_ovf_count", i), ovf_count, tbl[i].ecnt);
    end

    // Steady state at level 2 with simultaneous push and pop
    exp_cnt = 1;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_op = 3'd0; in_result = 5'(5 + i);
      q.push_back(exp_rec(3'd0, 5'(5 + i)));
      tick_a;
    end
    chk("ss_fill_level", level, 2);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_op = 3'(i % 5); in_result = 5'((i * 7) % 32);
      r = exp_rec(in_op, in_result);
      if (r[1]) exp_cnt++;
      void'(q.pop_front());
      q.push_back(r);
      tick_a;
      chk($sformatf("ss%0d_level", i), level, 2);
      chk($sformatf("ss%0d_head", i), {out_op, out_result, out_zero, out_ovf, out_err}, q[0]);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      void'(q.pop_front());
      tick_a;
      if (i == 0)
        chk("ss_drain_head", {out_op, out_result, out_zero, out_ovf, out_err}, q[0]);
    end
    out_ready = 1'b0;
    chk("ss_drain_level", level, 0);
    chk("ss_ovf_count", ovf_count, exp_cnt);

    // Narrow counter saturation, then reset with entries held
    b_in_valid = 1'b1; b_in_op = 3'd2; b_in_result = 5'b10000; b_out_ready = 1'b0;
    tick_a;
    chk("sat_cnt0", b_ovf_count, 1);
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_a;
      chk($sformatf("sat_cnt%0d", i + 1), b_ovf_count, (i + 2 > 3) ? 3 : i + 2);
      chk($sformatf("sat_level%0d", i + 1), b_level, 1);
    end
    b_out_ready = 1'b0;
    tick_a; tick_a;
    chk("sat_level_pre_rst", b_level, 3);
    chk("sat_head_ovf", b_out_ovf, 1);
    b_reset = 1'b1; b_out_ready = 1'b1;
    tick_a;
    chk("mid_rst_level", b_level, 0);
    chk("mid_rst_out_valid", b_out_valid, 0);
    chk("mid_rst_count", b_ovf_count, 0);
    chk("mid_rst_in_ready", b_in_ready, 1);
    b_reset = 1'b0; b_in_valid = 1'b0;
    tick_a;
    chk("post_rst_level", b_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
